// File: rtl/pattern_scan_ctrl.sv
// Sequencer for the serial pattern detector: shifts a latched word into the
// detector MSB first and accumulates hit statistics from its Moore output.
module pattern_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int POS_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] word,
    input  logic             det_outp,
    output logic             det_inp,
    output logic             det_step,
    output logic             det_clr_n,
    output logic             busy,
    output logic             done,
    output logic             hit_any,
    output logic [CNT_W-1:0] hit_count,
    output logic [POS_W-1:0] first_hit
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    localparam logic [POS_W-1:0] LAST = POS_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sr;
    logic [POS_W-1:0] k;
    logic             smp;
    logic [POS_W-1:0] smp_idx;

    // Detector output lags one step, so each sample belongs to bit k-1.
    always_comb begin
        state_nx = state;
        smp      = 1'b0;
        smp_idx  = k - POS_W'(1);
        unique case (state)
            IDLE: begin
                if (start) state_nx = CLEAR;
            end
            CLEAR: state_nx = SHIFT;
            SHIFT: begin
                smp = (k != '0);
                if (k == LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                smp      = 1'b1;
                smp_idx  = LAST;
                state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            sr        <= '0;
            k         <= '0;
            hit_count <= '0;
            first_hit <= '0;
            hit_any   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                sr        <= word;
                k         <= '0;
                hit_count <= '0;
                first_hit <= '0;
                hit_any   <= 1'b0;
            end
            if (state == SHIFT) begin
                sr <= sr << 1;
                k  <= k + POS_W'(1);
            end
            if (smp && det_outp) begin
                if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                if (!hit_any) begin
                    first_hit <= smp_idx;
                    hit_any   <= 1'b1;
                end
            end
        end
    end

    assign det_step  = (state == SHIFT);
    assign det_inp   = (state == SHIFT) && sr[WIDTH-1];
    assign det_clr_n = reset && (state != CLEAR);
    assign busy      = (state == CLEAR) || (state == SHIFT) ||
                       (state == DRAIN);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl with a one-register detector stub
// and a second instance (CNT_W=3, detector tied high) for saturation.
module tb_pattern_scan_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] word  = '0;
    logic        det_outp;
    logic        det_inp, det_step, det_clr_n, busy, done, hit_any;
    logic [4:0]  hit_count;
    logic [3:0]  first_hit;

    logic        s_inp, s_step, s_clr_n, s_busy, s_done, s_any;
    logic [2:0]  s_count;
    logic [3:0]  s_first;

    logic        stub_q;
    int          n_cmp = 0;
    int          n_err = 0;
    int          lat;
    int          dones;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!det_clr_n) stub_q <= 1'b0;
        else if (det_step) stub_q <= det_inp;
    end
    assign det_outp = stub_q;

    pattern_scan_ctrl #(.WIDTH(16), .CNT_W(5), .POS_W(4)) u_dut (
        .clock(clock), .reset(reset), .start(start), .word(word),
        .det_outp(det_outp), .det_inp(det_inp), .det_step(det_step),
        .det_clr_n(det_clr_n), .busy(busy), .done(done),
        .hit_any(hit_any), .hit_count(hit_count), .first_hit(first_hit)
    );

    pattern_scan_ctrl #(.WIDTH(16), .CNT_W(3), .POS_W(4)) u_sat (
        .clock(clock), .reset(reset), .start(start), .word(word),
        .det_outp(1'b1), .det_inp(s_inp), .det_step(s_step),
        .det_clr_n(s_clr_n), .busy(s_busy), .done(s_done),
        .hit_any(s_any), .hit_count(s_count), .first_hit(s_first)
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts a run from IDLE and returns when done is seen (or budget ends).
    task automatic run(input logic [15:0] w);
        word  = w;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        check("busy_in_clear", {31'b0, busy}, 1);
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        check("done_latency", lat, 19);
    endtask

    task automatic results(input string tag, input int cnt, input int pos,
                           input int any);
        check({tag, "_count"}, {27'b0, hit_count}, cnt);
        check({tag, "_first"}, {28'b0, first_hit}, pos);
        check({tag, "_any"}, {31'b0, hit_any}, any);
    endtask

    task automatic count_dones(input int n);
        dones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) dones++;
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_step", {31'b0, det_step}, 0);
        check("rst_inp", {31'b0, det_inp}, 0);
        check("rst_clr_n", {31'b0, det_clr_n}, 0);
        results("rst", 0, 0, 0);
        reset = 1'b1;
        tick();
        check("idle_clr_n", {31'b0, det_clr_n}, 1);

        run(16'h8001);
        results("w8001", 2, 0, 1);
        check("sat_count", {29'b0, s_count}, 7);
        check("sat_first", {28'b0, s_first}, 0);
        tick();
        check("hold_done_low", {31'b0, done}, 0);
        results("w8001_hold", 2, 0, 1);

        run(16'h0100);
        results("w0100", 1, 7, 1);
        tick();
        run(16'h0000);
        results("w0000", 0, 0, 0);
        tick();

        // Start requests mid-run and in DONE must be dropped.
        word  = 16'h0010;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        dones = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (lat == 5) begin
                start = 1'b1;
                word  = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
        end
        check("ign_latency", lat, 19);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_done_start", {31'b0, busy}, 0);
        results("ign", 1, 11, 1);
        count_dones(25);
        check("ign_extra_done", dones, 0);

        // Reset in the 8th SHIFT cycle (cycle 9 after start).
        word  = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("pre_abort_step", {31'b0, det_step}, 1);
        reset = 1'b0;
        tick();
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_clr_n", {31'b0, det_clr_n}, 0);
        check("abort_step", {31'b0, det_step}, 0);
        results("abort", 0, 0, 0);
        reset = 1'b1;
        count_dones(25);
        check("abort_no_done", dones, 0);
        run(16'h8001);
        results("post_abort", 2, 0, 1);

        tick();
        run(16'hFFFF);
        results("wFFFF", 16, 0, 1);
        tick();
        run(16'h0001);
        results("w0001", 1, 15, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
